// File: rtl/digit_uart_tx.sv
// Renders a latched 4-nibble digit word as ASCII hex characters on a UART 8N1 line.
// Optional macro DIGIT_TX_CRLF_EN appends CR, LF after the four digits.
module digit_uart_tx #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_tx_data1,
  input  logic [3:0] i_tx_data2,
  input  logic [3:0] i_tx_data3,
  input  logic [3:0] i_tx_data4,
  input  logic       i_tx_valid,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_uart_tx
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE = BW'(CLK_DIV - 2);
`ifdef DIGIT_TX_CRLF_EN
  localparam logic [2:0] LAST_CHR = 3'd5;
`else
  localparam logic [2:0] LAST_CHR = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      chr_q, chr_d;
  logic [15:0]     data_q, data_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  always_comb begin
    cur_char = 8'h00;
    case (chr_q)
      3'd0:    cur_char = hex_ascii(data_q[15:12]);
      3'd1:    cur_char = hex_ascii(data_q[11:8]);
      3'd2:    cur_char = hex_ascii(data_q[7:4]);
      3'd3:    cur_char = hex_ascii(data_q[3:0]);
`ifdef DIGIT_TX_CRLF_EN
      3'd4:    cur_char = 8'h0D;
      3'd5:    cur_char = 8'h0A;
`endif
      default: cur_char = 8'h00;
    endcase
  end

  // tx_d is the line level for the next cycle, so o_uart_tx stays registered
  // and the start bit lands in the first cycle after acceptance.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE)
      baud_d = (baud_q == BAUD_MAX) ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (i_tx_valid) begin
          data_d  = {i_tx_data1, i_tx_data2, i_tx_data3, i_tx_data4};
          state_d = START;
          baud_d  = '0;
          chr_d   = 3'd0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      START: if (baud_q == BAUD_MAX) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = cur_char[0];
      end
      DATA: if (baud_q == BAUD_MAX) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = cur_char[bit_q + 3'd1];
        end
      end
      STOP: begin
        done_d = (chr_q == LAST_CHR) && (baud_q == BAUD_PRE);
        if (baud_q == BAUD_MAX) begin
          if (chr_q == LAST_CHR) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = START;
            chr_d   = chr_q + 3'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      chr_q   <= 3'd0;
      data_q  <= 16'h0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;
endmodule

// File: doc/digit_uart_tx.md
Name: digit_uart_tx

Overview:
- Consumer end of the numpad digit interface.
- Accepts a 4-nibble digit word (i_tx_data1..4) on a valid/busy handshake and renders each nibble as one ASCII hex character.
- Serialises the characters on a UART 8N1 line, digit 1 first.
- Drives the busy flag that numpad throttles on, so o_tx_busy connects directly to numpad's i_tx_busy.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_tx_data1  input  4  first (most significant) digit
- i_tx_data2  input  4  second digit
- i_tx_data3  input  4  third digit
- i_tx_data4  input  4  fourth digit
- i_tx_valid  input  1  digit word valid
- o_tx_busy  output  1  frame in progress; new words are not accepted
- o_tx_done  output  1  one-cycle pulse at end of the last character
- o_uart_tx  output  1  serial line, idle high

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_uart_tx=1, o_tx_busy=0, o_tx_done=0.
  - All counters cleared; FSM goes to IDLE.
  - Applies mid-frame too: the line returns high on the next edge and the partial character is abandoned.
- Accept:
  - Rising edge with i_tx_valid=1 and o_tx_busy=0 latches all four nibbles.
  - Same edge sets o_tx_busy=1.
  - i_tx_valid while o_tx_busy=1 is ignored; there is no queueing.
- ASCII map:
  - Nibble 0-9 maps to 0x30+n.
  - Nibble A-F maps to 0x37+n (0x41..0x46, uppercase).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept.
  - START: drive 0 for CLK_DIV cycles -> DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each -> STOP.
  - STOP: drive 1 for CLK_DIV cycles.
    - Then START if characters remain, else IDLE.
- Latency: o_uart_tx falls on the first edge after the accept edge, i.e. the start bit is visible the cycle after acceptance.
- Characters are sent back-to-back with no inter-character idle. Each character is exactly 10*CLK_DIV cycles.
- Bit counter is 3 bits; character counter is 3 bits. Baud counter width is $clog2(CLK_DIV) and reloads to 0 at CLK_DIV-1, with no drift.
- Frame end:
  - On the final STOP cycle, o_tx_done=1 for exactly one cycle.
  - o_tx_busy=0 from the next cycle.
  - A word presented in that following cycle is accepted, giving a minimum gap of 1 idle cycle between frames.
- o_tx_busy stays high for exactly N*10*CLK_DIV cycles, where N=4 (or 6, see option).
- Latched digits are stable for the whole frame; input changes during busy do not affect the frame.
- All outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: DIGIT_TX_CRLF_EN
- Defined:
  - After the 4 digits, 0x0D then 0x0A are sent.
  - N=6; busy lasts 60*CLK_DIV cycles.
  - o_tx_done fires after the LF stop bit.
- Undefined:
  - Only 4 characters; busy lasts 40*CLK_DIV cycles.
  - No CR/LF logic synthesised.

Test Plan:
- Bench uses CLK_DIV=4, macro undefined unless noted.
- Word 1,2,3,4, valid for 1 cycle:
  - Line decodes 0x31,0x32,0x33,0x34.
  - Start bit appears 1 cycle after accept.
  - busy high for 160 cycles.
  - done pulses once on cycle 160.
- Word A,F,0,9:
  - Line decodes 0x41,0x46,0x30,0x39.
  - Bit pattern of 0x41 is 0,1,0,0,0,0,0,1,0,1 (start, LSB-first data, stop).
- Word 1,1,1,1, then word 2,2,2,2 pulsed at cycle 50 while busy:
  - Only 0x31 x4 sent; second word dropped.
  - busy falls at cycle 161; no second frame.
- Valid held high continuously with word 5,5,5,5:
  - Frames repeat with exactly 1 idle-high cycle between them.
  - Each frame is 0x35 x4.
- rst asserted at cycle 70 (mid second character) for 1 cycle:
  - Next edge: o_uart_tx=1, busy=0, done=0.
  - A new word 7,7,7,7 then transmits cleanly as 0x37 x4.
- DIGIT_TX_CRLF_EN defined, word 0,0,0,1:
  - Line decodes 0x30,0x30,0x30,0x31,0x0D,0x0A.
  - busy high for 240 cycles.
